alu_acc_ctrl: RTL and testbench
===============================

Name: alu_acc_ctrl

Overview:
- Execution sequencer directly upstream of the ALU+accumulator block; drives all of its control inputs.
- Accepts one decoded opcode per start pulse.
- Single-cycle ops (LDA/ADD/SUB/AND/OUT/NOP) issue one control word.
- Multi-cycle ops (MUL shift-add, DIV shift-subtract) step the datapath through DATA_W iterations and signal completion with busy/done.

Parameters:
- DATA_W, 4, operand width; iteration count for MUL/DIV.
- CNT_W, 3, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  3  000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 AND, 101 MUL, 110 DIV, 111 OUT.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- acc_high_reset_p  out  1  clears ACC high nibble (active-high, as consumed).
- rd_en  out  1  ACC drives bus.
- acc_in_select  out  1  0 = bus_data, 1 = alu_data.
- acc_high_select_in  out  2  00 hold, 01 shift right, 10 shift left, 11 load.
- acc_low_select  out  2  same encoding as acc_high_select_in.
- op_add, op_sub, op_mul, op_div, op_and  out  1 each  ALU op strobes; at most one high in any cycle.

Behaviour:
- All outputs are registered.
- Reset (reset_n = 0 at a rising edge) forces state IDLE and counter 0. Every output is 0 from the next cycle, including in the middle of MUL/DIV. No done pulse is produced for an aborted op.
- States: IDLE, EXEC, MUL_INIT, MUL_ADD, MUL_SHIFT, DIV_INIT, DIV_SHIFT, DIV_SUB, DONE.
- IDLE with start = 1 at edge k: opcode latched.
  - MUL → MUL_INIT; DIV → DIV_INIT; all others → EXEC.
  - start while not IDLE is ignored (not queued). opcode changes after acceptance are ignored.
- EXEC (1 cycle), then → DONE:
  - NOP: all controls 0.
  - LDA: acc_in_select = 0, acc_low_select = 11.
  - ADD/SUB/AND: matching op strobe, acc_in_select = 1, acc_high_select_in = 11.
  - OUT: rd_en = 1.
- MUL_INIT: acc_high_reset_p = 1; counter ← 0; → MUL_ADD.
- MUL_ADD: op_mul = 1, acc_in_select = 1; the datapath conditions the load on the multiplier LSB; → MUL_SHIFT.
- MUL_SHIFT: acc_high_select_in = 01, acc_low_select = 01, counter +1. If the counter was DATA_W-1 → DONE, else → MUL_ADD.
- DIV_INIT: acc_high_reset_p = 1; counter ← 0; → DIV_SHIFT.
- DIV_SHIFT: acc_high_select_in = 10, acc_low_select = 10; → DIV_SUB.
- DIV_SUB: op_div = 1, acc_in_select = 1, counter +1. If the counter was DATA_W-1 → DONE, else → DIV_SHIFT.
- DONE: done = 1, busy = 1, all datapath controls 0; → IDLE.
- Latency (start at edge k):
  - Single-cycle ops: control word in cycle k+1, done in cycle k+2.
  - MUL/DIV: 1 init + 2·DATA_W + done = 10 busy cycles for DATA_W = 4; done in cycle k+10.
- A new start is accepted on the edge that leaves DONE only if it is asserted in IDLE, so back-to-back ops are spaced by at least 1 IDLE cycle.
- The counter does not wrap during an op. It is cleared in each INIT state.
- Every datapath control output is 0 in IDLE.

Decomposition:
- Shared package: opcode constants (OP_NOP … OP_OUT), select encodings (SEL_HOLD = 00, SEL_SHR = 01, SEL_SHL = 10, SEL_LOAD = 11), state enum.
- One sub-module: iter_counter (clear, increment, last flag at DATA_W-1).
- FSM and output decode stay in alu_acc_ctrl.

Test Plan:
- Reset mid-MUL: start with opcode = 101, assert reset_n = 0 in cycle k+4 → all outputs 0 next cycle, no done, IDLE thereafter.
- ADD: start with opcode = 010 at edge k → cycle k+1 has op_add = 1, acc_in_select = 1, acc_high_select_in = 11; cycle k+2 has done = 1; busy high for exactly 2 cycles.
- MUL trace: opcode = 101 → cycle k+1 acc_high_reset_p = 1, then op_mul alternating with (01, 01) shifts, 4 times each; done in cycle k+10; connected to alu_acc, 3×5 yields acc_data = 0x0F.
- DIV trace: opcode = 110 → pattern (10, 10) shift then op_div, 4 times; done in cycle k+10; connected datapath, 13/4 gives quotient 3, remainder 1.
- Start ignored while busy: pulse start with opcode = 010 during a MUL → no extra op strobes; single done at k+10.
- NOP/OUT: opcode = 000 → all controls 0, done at k+2; opcode = 111 → rd_en = 1 only in cycle k+1.

Source files
------------

// File: rtl/alu_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_ctrl_pkg
//  Description : Shared constants for the ALU+accumulator execution sequencer.
//                It holds the opcode map, the shift/load select encodings,
//                the sequencer state codes and the control-word structure.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_acc_ctrl_pkg;

   // Decoded opcodes
   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_OUT = 3'b111;

   // Accumulator half-register select encodings
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   // Sequencer states
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_EXEC      = 4'd1;
   localparam logic [3:0] ST_MUL_INIT  = 4'd2;
   localparam logic [3:0] ST_MUL_ADD   = 4'd3;
   localparam logic [3:0] ST_MUL_SHIFT = 4'd4;
   localparam logic [3:0] ST_DIV_INIT  = 4'd5;
   localparam logic [3:0] ST_DIV_SHIFT = 4'd6;
   localparam logic [3:0] ST_DIV_SUB   = 4'd7;
   localparam logic [3:0] ST_DONE      = 4'd8;

   // Complete registered output word of the sequencer
   typedef struct packed {
      logic       busy;
      logic       done;
      logic       acc_high_reset_p;
      logic       rd_en;
      logic       acc_in_select;
      logic [1:0] acc_high_select_in;
      logic [1:0] acc_low_select;
      logic       op_add;
      logic       op_sub;
      logic       op_mul;
      logic       op_div;
      logic       op_and;
   } ctrl_t;

endpackage : alu_acc_ctrl_pkg
`default_nettype wire

// File: rtl/alu_acc_ctrl_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : iter_counter
//  Description : Iteration counter for the MUL/DIV loops. It clears at the
//                start of an operation, advances once per loop pass and flags
//                the final pass (count == DATA_W-1).
//  Revision    : 1.0  initial release
// ============================================================================
module iter_counter #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_incr,
   output logic o_last
);

   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0] r_count;

   // Clear has priority over increment; loops never run past LAST_VAL
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_incr) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_last = (r_count == LAST_VAL);

endmodule : iter_counter
`default_nettype wire

// File: rtl/alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_ctrl
//  Description : Execution sequencer for the ALU+accumulator block. Single-
//                cycle ops issue one control word. MUL (shift-add) and DIV
//                (shift-subtract) step the datapath through DATA_W passes.
//                Every output is registered and is decoded from the next state.
//                DATA_W must fit the counter: 2**CNT_W > DATA_W.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_acc_ctrl
   import alu_acc_ctrl_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [2:0] opcode,
   output logic       busy,
   output logic       done,
   output logic       acc_high_reset_p,
   output logic       rd_en,
   output logic       acc_in_select,
   output logic [1:0] acc_high_select_in,
   output logic [1:0] acc_low_select,
   output logic       op_add,
   output logic       op_sub,
   output logic       op_mul,
   output logic       op_div,
   output logic       op_and
);

   logic [3:0] r_state;
   logic [3:0] w_state_next;
   logic [2:0] r_opcode;
   logic [2:0] w_op_eff;
   logic       w_accept;
   logic       w_cnt_clear;
   logic       w_cnt_incr;
   logic       w_cnt_last;
   ctrl_t      r_ctrl;
   ctrl_t      w_ctrl_next;

   // Control word presented while the sequencer sits in state st
   function automatic ctrl_t decode_ctrl(input logic [3:0] st, input logic [2:0] op);
      ctrl_t c;
      c = '0;
      case (st)
         ST_EXEC: begin
            c.busy = 1'b1;
            case (op)
               OP_LDA: begin
                  c.acc_in_select  = 1'b0;
                  c.acc_low_select = SEL_LOAD;
               end
               OP_ADD: begin
                  c.op_add             = 1'b1;
                  c.acc_in_select      = 1'b1;
                  c.acc_high_select_in = SEL_LOAD;
               end
               OP_SUB: begin
                  c.op_sub             = 1'b1;
                  c.acc_in_select      = 1'b1;
                  c.acc_high_select_in = SEL_LOAD;
               end
               OP_AND: begin
                  c.op_and             = 1'b1;
                  c.acc_in_select      = 1'b1;
                  c.acc_high_select_in = SEL_LOAD;
               end
               OP_OUT:  c.rd_en = 1'b1;
               default: ;
            endcase
         end
         ST_MUL_INIT, ST_DIV_INIT: begin
            c.busy             = 1'b1;
            c.acc_high_reset_p = 1'b1;
         end
         ST_MUL_ADD: begin
            c.busy          = 1'b1;
            c.op_mul        = 1'b1;
            c.acc_in_select = 1'b1;
         end
         ST_MUL_SHIFT: begin
            c.busy               = 1'b1;
            c.acc_high_select_in = SEL_SHR;
            c.acc_low_select     = SEL_SHR;
         end
         ST_DIV_SHIFT: begin
            c.busy               = 1'b1;
            c.acc_high_select_in = SEL_SHL;
            c.acc_low_select     = SEL_SHL;
         end
         ST_DIV_SUB: begin
            c.busy          = 1'b1;
            c.op_div        = 1'b1;
            c.acc_in_select = 1'b1;
         end
         ST_DONE: begin
            c.busy = 1'b1;
            c.done = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   assign w_accept = (r_state == ST_IDLE) && start;
   // The word for EXEC is decoded on the accepting edge, before r_opcode updates
   assign w_op_eff = w_accept ? opcode : r_opcode;

   // Counter clears on leaving an INIT state and advances once per loop pass
   assign w_cnt_clear = (r_state == ST_MUL_INIT) || (r_state == ST_DIV_INIT);
   assign w_cnt_incr  = (r_state == ST_MUL_SHIFT) || (r_state == ST_DIV_SUB);

   iter_counter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_iter_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (w_cnt_clear),
      .i_incr  (w_cnt_incr),
      .o_last  (w_cnt_last)
   );

   // Next-state logic; start outside IDLE is dropped
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               case (opcode)
                  OP_MUL:  w_state_next = ST_MUL_INIT;
                  OP_DIV:  w_state_next = ST_DIV_INIT;
                  default: w_state_next = ST_EXEC;
               endcase
            end
         end
         ST_EXEC:      w_state_next = ST_DONE;
         ST_MUL_INIT:  w_state_next = ST_MUL_ADD;
         ST_MUL_ADD:   w_state_next = ST_MUL_SHIFT;
         ST_MUL_SHIFT: w_state_next = w_cnt_last ? ST_DONE : ST_MUL_ADD;
         ST_DIV_INIT:  w_state_next = ST_DIV_SHIFT;
         ST_DIV_SHIFT: w_state_next = ST_DIV_SUB;
         ST_DIV_SUB:   w_state_next = w_cnt_last ? ST_DONE : ST_DIV_SHIFT;
         ST_DONE:      w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with r_state
   always_comb begin
      w_ctrl_next = decode_ctrl(w_state_next, w_op_eff);
   end

   // State, latched opcode and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_opcode <= OP_NOP;
         r_ctrl   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ctrl  <= w_ctrl_next;
         if (w_accept) begin
            r_opcode <= opcode;
         end
      end
   end

   assign busy               = r_ctrl.busy;
   assign done               = r_ctrl.done;
   assign acc_high_reset_p   = r_ctrl.acc_high_reset_p;
   assign rd_en              = r_ctrl.rd_en;
   assign acc_in_select      = r_ctrl.acc_in_select;
   assign acc_high_select_in = r_ctrl.acc_high_select_in;
   assign acc_low_select     = r_ctrl.acc_low_select;
   assign op_add             = r_ctrl.op_add;
   assign op_sub             = r_ctrl.op_sub;
   assign op_mul             = r_ctrl.op_mul;
   assign op_div             = r_ctrl.op_div;
   assign op_and             = r_ctrl.op_and;

endmodule : alu_acc_ctrl
`default_nettype wire

// File: tb/tb_alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_acc_ctrl
//  Description : Scoreboard bench for alu_acc_ctrl. A reference model turns
//                each accepted opcode into the list of control words expected
//                on the following cycles. A monitor pops one word per busy
//                cycle and requires all-zero outputs while idle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_acc_ctrl;

   localparam int DATA_W = 4;
   localparam int CNT_W  = 3;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       start   = 1'b0;
   logic [2:0] opcode  = 3'b000;

   logic       busy, done, acc_high_reset_p, rd_en, acc_in_select;
   logic [1:0] acc_high_select_in, acc_low_select;
   logic       op_add, op_sub, op_mul, op_div, op_and;

   logic [13:0] dut_word;
   logic [13:0] exp_q[$];
   int          rem      = 0;
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          mon_en   = 1'b0;

   always #5 clk = ~clk;

   alu_acc_ctrl #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .start              (start),
      .opcode             (opcode),
      .busy               (busy),
      .done               (done),
      .acc_high_reset_p   (acc_high_reset_p),
      .rd_en              (rd_en),
      .acc_in_select      (acc_in_select),
      .acc_high_select_in (acc_high_select_in),
      .acc_low_select     (acc_low_select),
      .op_add             (op_add),
      .op_sub             (op_sub),
      .op_mul             (op_mul),
      .op_div             (op_div),
      .op_and             (op_and)
   );

   assign dut_word = {busy, done, acc_high_reset_p, rd_en, acc_in_select,
                      acc_high_select_in, acc_low_select,
                      op_add, op_sub, op_mul, op_div, op_and};

   // Word order: busy done hr rd insel hsel lsel add sub mul div and
   function automatic logic [13:0] cw(input bit d, input bit hr, input bit rd,
                                      input bit ins, input logic [1:0] hs,
                                      input logic [1:0] ls, input bit a,
                                      input bit s, input bit m, input bit dv,
                                      input bit an);
      return {1'b1, d, hr, rd, ins, hs, ls, a, s, m, dv, an};
   endfunction

   function automatic void check(input string name, input logic [13:0] got,
                                 input logic [13:0] req);
      n_checks++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got %b required %b at %0t", name, got, req, $time);
   endfunction

   // Expected busy-cycle words for one operation; returns how many were queued
   function automatic int push_op(input logic [2:0] op);
      int n;
      n = exp_q.size();
      case (op)
         3'd0: exp_q.push_back(cw(0,0,0,0,2'b00,2'b00,0,0,0,0,0));
         3'd1: exp_q.push_back(cw(0,0,0,0,2'b00,2'b11,0,0,0,0,0));
         3'd2: exp_q.push_back(cw(0,0,0,1,2'b11,2'b00,1,0,0,0,0));
         3'd3: exp_q.push_back(cw(0,0,0,1,2'b11,2'b00,0,1,0,0,0));
         3'd4: exp_q.push_back(cw(0,0,0,1,2'b11,2'b00,0,0,0,0,1));
         3'd7: exp_q.push_back(cw(0,0,1,0,2'b00,2'b00,0,0,0,0,0));
         3'd5: begin
            exp_q.push_back(cw(0,1,0,0,2'b00,2'b00,0,0,0,0,0));
            for (int i = 0; i < DATA_W; i++) begin
               exp_q.push_back(cw(0,0,0,1,2'b00,2'b00,0,0,1,0,0));
               exp_q.push_back(cw(0,0,0,0,2'b01,2'b01,0,0,0,0,0));
            end
         end
         default: begin
            exp_q.push_back(cw(0,1,0,0,2'b00,2'b00,0,0,0,0,0));
            for (int i = 0; i < DATA_W; i++) begin
               exp_q.push_back(cw(0,0,0,0,2'b10,2'b10,0,0,0,0,0));
               exp_q.push_back(cw(0,0,0,1,2'b00,2'b00,0,0,0,1,0));
            end
         end
      endcase
      exp_q.push_back(cw(1,0,0,0,2'b00,2'b00,0,0,0,0,0));
      return exp_q.size() - n;
   endfunction

   // Reference model: accepts a start only when its previous op has fully ended
   always @(posedge clk) begin
      if (!reset_n) begin
         rem = 0;
         exp_q.delete();
      end else if (rem == 0 && start) begin
         rem = push_op(opcode);
      end else if (rem > 0) begin
         rem--;
      end
   end

   // Monitor: each busy cycle consumes one expected word
   always @(negedge clk) begin
      if (mon_en) begin
         if (busy === 1'b1) begin
            if (exp_q.size() == 0) check("busy_unexpected", {13'b0, busy}, 14'd0);
            else check("ctrl_word", dut_word, exp_q.pop_front());
         end else begin
            check("idle_word", dut_word, 14'd0);
            if (exp_q.size() != 0) begin
               check("busy_missing", {13'b0, busy}, 14'd1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle();
      int guard = 0;
      while (rem != 0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         n_checks++;
         $display("FAIL wait_idle: got timeout required idle at %0t", $time);
      end
   endtask

   task automatic issue(input logic [2:0] op);
      wait_idle();
      start  = 1'b1;
      opcode = op;
      @(negedge clk);
      start  = 1'b0;
      opcode = 3'($urandom);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      mon_en  = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);

      // Directed: each opcode once
      issue(3'b010);
      issue(3'b000);
      issue(3'b111);
      issue(3'b001);
      issue(3'b011);
      issue(3'b100);
      issue(3'b110);

      // MUL with a stray ADD start while busy
      issue(3'b101);
      repeat (3) @(negedge clk);
      start  = 1'b1;
      opcode = 3'b010;
      @(negedge clk);
      start  = 1'b0;

      // Reset in cycle k+4 of a MUL
      issue(3'b101);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // Back-to-back: start held high continuously
      wait_idle();
      start  = 1'b1;
      opcode = 3'b010;
      repeat (8) @(negedge clk);
      start  = 1'b0;

      // Random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(0, 2) == 0);
         opcode  = 3'($urandom);
         reset_n = ($urandom_range(0, 99) != 0);
         @(negedge clk);
      end
      reset_n = 1'b1;
      start   = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("drain_queue", 14'(exp_q.size()), 14'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_alu_acc_ctrl
`default_nettype wire
